// File: rtl/param_alu_pkg.sv
// Shared types for the parameterised ALU: opcode encoding, FSM states and
// a small opcode classification helper.
package param_alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OPC_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OPC_ADD   = 3'd1;
    localparam logic [OP_W-1:0] OPC_SUB   = 3'd2;
    localparam logic [OP_W-1:0] OPC_XOR   = 3'd3;
    localparam logic [OP_W-1:0] OPC_MUL   = 3'd4;
    localparam logic [OP_W-1:0] OPC_WRITE = 3'd5;
    localparam logic [OP_W-1:0] OPC_READ  = 3'd6;
    localparam logic [OP_W-1:0] OPC_RSVD  = 3'd7;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = OPC_NOP,
        OP_ADD   = OPC_ADD,
        OP_SUB   = OPC_SUB,
        OP_XOR   = OPC_XOR,
        OP_MUL   = OPC_MUL,
        OP_WRITE = OPC_WRITE,
        OP_READ  = OPC_READ,
        OP_RSVD  = OPC_RSVD
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operations whose B operand is a register-map index rather than data.
    function automatic logic op_uses_index(input op_e op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/param_alu_if.sv
// Request/response bundle between a requester and the ALU.
interface param_alu_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               error;

    modport master (
        output A, B, op, start,
        input  busy, done, result, error
    );

    modport slave (
        input  A, B, op, start,
        output busy, done, result, error
    );

endinterface

// File: rtl/param_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first partial product is folded into the load cycle, so the product
// is complete WIDTH-1 edges after go and fin is raised during that cycle.
module param_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               fin,
    output logic [2*WIDTH-1:0] product
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    acc;

    // Control: busy flag and remaining-step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (go) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH - 1);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Datapath: load with bit 0 already applied, then one shift-add per cycle.
    always_ff @(posedge clk) begin
        if (go) begin
            acc    <= b[0] ? RW'(a) : '0;
            mcand  <= RW'(a) << 1;
            mplier <= b >> 1;
        end else if (busy && (cnt != '0)) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign fin     = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/param_alu.sv
// Parameterised multi-cycle ALU with a small register map.
// IDLE -> RUN on accept, RUN -> DONE when the operation completes, and a
// new request may be accepted straight from DONE for back-to-back use.
module param_alu
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REGS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    param_alu_if.slave bus
);

    localparam int RW    = 2 * WIDTH;
    localparam int IDX_W = (REGS > 1) ? $clog2(REGS) : 1;

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             finish;
    logic             mul_go;

    op_e              op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;

    logic [WIDTH-1:0] reg_map [REGS];
    logic [WIDTH-1:0] rd_data;

    logic             mul_busy;
    logic             mul_fin;
    logic [RW-1:0]    product;

    logic [RW-1:0]    res_c;
    logic             err_c;
    logic [RW-1:0]    result_q;
    logic             error_q;

    function automatic logic idx_ok(input logic [WIDTH-1:0] idx);
        return 32'(idx) < 32'(REGS);
    endfunction

    param_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .go      (mul_go),
        .a       (bus.A),
        .b       (bus.B),
        .busy    (mul_busy),
        .fin     (mul_fin),
        .product (product)
    );

    // FSM state register; reset wins over any same-edge start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, accept and completion decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                finish = (op_p0 != OP_MUL) || (mul_busy && mul_fin);
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        mul_go = accept && (bus.op == OPC_MUL);
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= op_e'(bus.op);
            a_p0  <= bus.A;
            b_p0  <= bus.B;
        end
    end

    // Register map: cleared by reset, written on the accepting edge of WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) begin
                reg_map[i] <= '0;
            end
        end else if (accept && (bus.op == OPC_WRITE) && idx_ok(bus.B)) begin
            reg_map[bus.B[IDX_W-1:0]] <= bus.A;
        end
    end

    // Result and error for the operation currently in RUN.
    always_comb begin
        res_c   = '0;
        err_c   = 1'b0;
        rd_data = reg_map[b_p0[IDX_W-1:0]];
        case (op_p0)
            OP_ADD:  res_c = RW'(a_p0) + RW'(b_p0);
            OP_SUB:  res_c = RW'(a_p0) - RW'(b_p0);
            OP_XOR:  res_c = RW'(a_p0 ^ b_p0);
            OP_MUL:  res_c = product;
            OP_READ: begin
                if (idx_ok(b_p0)) begin
                    res_c = RW'(rd_data);
                end
            end
            OP_RSVD: err_c = 1'b1;
            default: res_c = '0;
        endcase
        if (op_uses_index(op_p0) && !idx_ok(b_p0)) begin
            err_c = 1'b1;
        end
    end

    // Output registers: result holds between completions, error lives only with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (finish) begin
                result_q <= res_c;
                error_q  <= err_c;
            end
        end
    end

    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu at WIDTH=8, REGS=4.
module tb_param_alu;
    import param_alu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_alu_if #(.WIDTH(8)) bus ();

    param_alu #(
        .WIDTH (8),
        .REGS  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, then follow it cycle by cycle to the done pulse.
    // poke_at > 0 raises an ADD start on that RUN cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] opc, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input int poke_at);
        bus.op    = opc;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        step();
        check({tag, " busy@accept"}, bus.busy, 1);
        check({tag, " done@accept"}, bus.done, 0);
        bus.start = 1'b0;
        for (int i = 1; i < lat; i++) begin
            if (i == poke_at) begin
                bus.start = 1'b1;
                bus.op    = OPC_ADD;
                bus.A     = 8'h01;
                bus.B     = 8'h01;
            end
            step();
            bus.start = 1'b0;
            check({tag, " busy@run"}, bus.busy, 1);
            check({tag, " done@run"}, bus.done, 0);
        end
        step();
        check({tag, " done"}, bus.done, 1);
        check({tag, " busy@done"}, bus.busy, 0);
    endtask

    task automatic check_out(input string tag, input logic [15:0] res, input logic err);
        check({tag, " result"}, bus.result, res);
        check({tag, " error"}, bus.error, err);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OPC_NOP;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        step();
        step();
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset error", bus.error, 0);
        check("reset result", bus.result, 0);
        reset = 1'b0;
        step();

        run_op("add", OPC_ADD, 8'hFF, 8'h01, 1, -1);
        check_out("add", 16'h0100, 1'b0);
        step();
        check("add hold result", bus.result, 16'h0100);
        check("add hold done", bus.done, 0);
        check("add hold error", bus.error, 0);

        run_op("mul ff", OPC_MUL, 8'hFF, 8'hFF, 8, 3);
        check_out("mul ff", 16'hFE01, 1'b0);
        run_op("mul 12x34", OPC_MUL, 8'h12, 8'h34, 8, -1);
        check_out("mul 12x34", 16'h03A8, 1'b0);
        run_op("mul 03x80", OPC_MUL, 8'h03, 8'h80, 8, -1);
        check_out("mul 03x80", 16'h0180, 1'b0);
        step();

        run_op("write r2", OPC_WRITE, 8'h5A, 8'h02, 1, -1);
        check_out("write r2", 16'h0000, 1'b0);
        run_op("read r2", OPC_READ, 8'h00, 8'h02, 1, -1);
        check_out("read r2", 16'h005A, 1'b0);
        run_op("read r7", OPC_READ, 8'h00, 8'h07, 1, -1);
        check_out("read r7", 16'h0000, 1'b1);
        step();
        check("error idle", bus.error, 0);

        run_op("write r5", OPC_WRITE, 8'h77, 8'h05, 1, -1);
        check_out("write r5", 16'h0000, 1'b1);
        run_op("read r1", OPC_READ, 8'h00, 8'h01, 1, -1);
        check_out("read r1", 16'h0000, 1'b0);

        run_op("sub", OPC_SUB, 8'h01, 8'h02, 1, -1);
        check_out("sub", 16'hFFFF, 1'b0);
        run_op("rsvd", OPC_RSVD, 8'h12, 8'h34, 1, -1);
        check_out("rsvd", 16'h0000, 1'b1);
        run_op("xor", OPC_XOR, 8'hA5, 8'h0F, 1, -1);
        check_out("xor", 16'h00AA, 1'b0);
        run_op("nop", OPC_NOP, 8'h33, 8'h44, 1, -1);
        check_out("nop", 16'h0000, 1'b0);

        run_op("write r3", OPC_WRITE, 8'h33, 8'h03, 1, -1);
        run_op("write r0", OPC_WRITE, 8'h11, 8'h00, 1, -1);
        run_op("read r3", OPC_READ, 8'h00, 8'h03, 1, -1);
        check_out("read r3", 16'h0033, 1'b0);
        step();

        // Abort a MUL three cycles in, with a start pending on the reset edge.
        bus.op    = OPC_MUL;
        bus.A     = 8'h12;
        bus.B     = 8'h34;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("abort busy@accept", bus.busy, 1);
        step();
        step();
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort no done", bus.done, 0);
        end

        for (int i = 0; i < 4; i++) begin
            run_op("read cleared", OPC_READ, 8'h00, 8'(i), 1, -1);
            check_out("read cleared", 16'h0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
